// File: rtl/uart_reg_cmd_decoder.sv
// uart_reg_cmd_decoder
//   Turns the UART receiver's byte stream into register-file accesses.
//   A command byte carries R/nW in bit 7 and a 7-bit address. A read
//   command pulses o_rd_en. A write command is followed by DATA_BYTES
//   data bytes (MSB first) and then pulses o_wr_en with the assembled
//   word. If a write frame stalls for TIMEOUT idle cycles between bytes,
//   it is dropped and o_timeout pulses.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a command byte
//   DATA  | collecting write data bytes; inter-byte timer running
//
// Ports
//   clk          in   clock
//   i_reset      in   synchronous active-high reset
//   i_data       in   received byte, sampled in the accept cycle
//   i_data_valid in   level valid from the receiver; a byte is taken on its rising edge
//   o_addr       out  address of the last decoded command (held)
//   o_wdata      out  data of the last completed write (held)
//   o_wr_en      out  one-cycle write strobe
//   o_rd_en      out  one-cycle read strobe
//   o_timeout    out  one-cycle pulse when a partial write frame is dropped
//   o_busy       out  high while a write frame is being collected
module uart_reg_cmd_decoder #(
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_data,
  input  logic                    i_data_valid,
  output logic [6:0]              o_addr,
  output logic [8*DATA_BYTES-1:0] o_wdata,
  output logic                    o_wr_en,
  output logic                    o_rd_en,
  output logic                    o_timeout,
  output logic                    o_busy
);

  localparam int WW  = 8 * DATA_BYTES;
  localparam int BCW = $clog2(DATA_BYTES + 1);
  localparam int TCW = $clog2(TIMEOUT);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t         state_q;
  logic           valid_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [TCW-1:0] tmo_cnt_q;

  logic           accept;
  logic           shift_en;
  logic           shadow_clr;
  logic [WW-1:0]  word_d;

  // valid_q resets high so a byte already present at reset release is not
  // mistaken for a new one.
  assign accept     = i_data_valid & ~valid_q;
  assign shift_en   = (state_q == S_DATA) && accept;
  // Shadow is discarded on a new write command and on a timeout.
  assign shadow_clr = ((state_q == S_IDLE) && accept && !i_data[7]) ||
                      ((state_q == S_DATA) && !accept && (tmo_cnt_q == TMO_LAST));
  assign o_busy     = (state_q == S_DATA);

  // The shadow only needs to hold the first DATA_BYTES-1 bytes; the last
  // byte goes straight from i_data into the completed word.
  generate
    if (DATA_BYTES > 1) begin : g_shadow
      logic [WW-9:0] shadow_q;

      always_ff @(posedge clk) begin
        if (i_reset || shadow_clr) begin
          shadow_q <= '0;
        end else if (shift_en) begin
          shadow_q <= word_d[WW-9:0];
        end
      end

      assign word_d = {shadow_q, i_data};
    end else begin : g_no_shadow
      assign word_d = i_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b1;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_wr_en    <= 1'b0;
      o_rd_en    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      valid_q   <= i_data_valid;
      o_wr_en   <= 1'b0;
      o_rd_en   <= 1'b0;
      o_timeout <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            o_addr <= i_data[6:0];
            if (i_data[7]) begin
              o_rd_en <= 1'b1;
            end else begin
              byte_cnt_q <= '0;
              tmo_cnt_q  <= '0;
              state_q    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          // An accept in the terminal timer cycle takes priority over the timeout.
          if (accept) begin
            tmo_cnt_q <= '0;
            if (byte_cnt_q == LAST_BYTE) begin
              o_wdata    <= word_d;
              o_wr_en    <= 1'b1;
              byte_cnt_q <= '0;
              state_q    <= S_IDLE;
            end else begin
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            o_timeout  <= 1'b1;
            tmo_cnt_q  <= '0;
            byte_cnt_q <= '0;
            state_q    <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TCW'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd_decoder.sv
module tb_uart_reg_cmd_decoder;

  localparam int DB  = 4;
  localparam int TMO = 16;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_TMO  = 3;

  logic          clk;
  logic          i_reset;
  logic [7:0]    i_data;
  logic          i_data_valid;
  logic [6:0]    o_addr;
  logic [8*DB-1:0] o_wdata;
  logic          o_wr_en;
  logic          o_rd_en;
  logic          o_timeout;
  logic          o_busy;

  uart_reg_cmd_decoder #(.DATA_BYTES(DB), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_addr       (o_addr),
    .o_wdata      (o_wdata),
    .o_wr_en      (o_wr_en),
    .o_rd_en      (o_rd_en),
    .o_timeout    (o_timeout),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    int          hi;
    int          lo;
    int          kind;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  typedef struct {
    int          kind;
    int          cyc;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Strobe monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (o_wr_en === 1'b1 || o_rd_en === 1'b1 || o_timeout === 1'b1) begin
      int   ak;
      exp_t e;
      ak = (o_wr_en === 1'b1) ? K_WR : (o_rd_en === 1'b1) ? K_RD : K_TMO;
      chk("strobe_exclusive", 64'(o_wr_en + o_rd_en + o_timeout), 64'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: kind %0d at cycle %0d, expected none", ak, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind",  64'(ak), 64'(e.kind));
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        chk("strobe_addr",  64'(o_addr), 64'(e.addr));
        chk("strobe_wdata", 64'(o_wdata), 64'(e.wdata));
      end
    end
  end

  // Called at a negedge; the byte is accepted in the current cycle, so any
  // resulting strobe appears one cycle later.
  task automatic send(input logic [7:0] b, input int hi, input int lo,
                      input int kind, input logic [6:0] a, input logic [31:0] w);
    exp_t e;
    i_data       = b;
    i_data_valid = 1'b1;
    if (kind != K_NONE) begin
      e = '{kind, cyc + 1, a, w};
      exp_q.push_back(e);
    end
    repeat (hi) @(negedge clk);
    i_data_valid = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},    64'(o_addr),    64'd0);
    chk({tag, "_wdata"},   64'(o_wdata),   64'd0);
    chk({tag, "_wr_en"},   64'(o_wr_en),   64'd0);
    chk({tag, "_rd_en"},   64'(o_rd_en),   64'd0);
    chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
    chk({tag, "_busy"},    64'(o_busy),    64'd0);
  endtask

  initial begin
    int   t;
    int   c;
    exp_t e;
    logic [7:0] race_bytes [4];

    // Byte already valid across reset release must be ignored.
    i_reset      = 1'b1;
    i_data       = 8'h85;
    i_data_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    i_reset = 1'b0;
    repeat (4) @(negedge clk);
    i_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_valid_addr", 64'(o_addr), 64'd0);

    // Write, read-and-hold, long valid level, minimum-spacing write.
    vecs.push_back('{8'h05, 10, 5,   K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'hDE, 10, 5,   K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'hAD, 10, 5,   K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'hBE, 10, 5,   K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'hEF, 10, 5,   K_WR,   7'h05, 32'hDEADBEEF});
    vecs.push_back('{8'h85, 10, 5,   K_RD,   7'h05, 32'hDEADBEEF});
    vecs.push_back('{8'h81, 200, 5,  K_RD,   7'h01, 32'hDEADBEEF});
    vecs.push_back('{8'h7F, 1, 1,    K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'h00, 1, 1,    K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'hFF, 1, 1,    K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'h00, 1, 1,    K_NONE, 7'h00, 32'h0});
    vecs.push_back('{8'hA5, 1, 3,    K_WR,   7'h7F, 32'h00FF00A5});

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].kind, vecs[i].addr, vecs[i].wdata);
      if (i == 4) chk("write_busy_after", 64'(o_busy), 64'd0);
    end
    chk("table_addr",  64'(o_addr),  64'h7F);
    chk("table_wdata", 64'(o_wdata), 64'h00FF00A5);
    chk("table_busy",  64'(o_busy),  64'd0);

    // Timeout: last accept in cycle t, pulse expected in t+TMO+1.
    send(8'h03, 1, 1, K_NONE, 7'h00, 32'h0);
    i_data       = 8'h11;
    i_data_valid = 1'b1;
    t = cyc;
    e = '{K_TMO, t + TMO + 1, 7'h03, 32'h00FF00A5};
    exp_q.push_back(e);
    @(negedge clk);
    i_data_valid = 1'b0;
    while (cyc < t + TMO) @(negedge clk);
    chk("tmo_busy_before", 64'(o_busy), 64'd1);
    chk("tmo_not_early",   64'(o_timeout), 64'd0);
    @(negedge clk);
    chk("tmo_busy_fall", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("tmo_one_cycle", 64'(o_timeout), 64'd0);
    chk("tmo_wdata_kept", 64'(o_wdata), 64'h00FF00A5);
    send(8'h83, 1, 2, K_RD, 7'h03, 32'h00FF00A5);

    // Accept lands exactly in the terminal timer cycle for every data byte.
    race_bytes[0] = 8'h12;
    race_bytes[1] = 8'h34;
    race_bytes[2] = 8'h56;
    race_bytes[3] = 8'h78;
    i_data       = 8'h10;
    i_data_valid = 1'b1;
    c = cyc;
    @(negedge clk);
    i_data_valid = 1'b0;
    for (int k = 0; k < DB; k++) begin
      while (cyc < c + TMO) @(negedge clk);
      chk("race_busy", 64'(o_busy), 64'd1);
      i_data       = race_bytes[k];
      i_data_valid = 1'b1;
      c = cyc;
      if (k == DB - 1) begin
        e = '{K_WR, c + 1, 7'h10, 32'h12345678};
        exp_q.push_back(e);
      end
      @(negedge clk);
      i_data_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("race_wdata", 64'(o_wdata), 64'h12345678);
    chk("race_busy_end", 64'(o_busy), 64'd0);

    // Reset in the middle of a write frame.
    send(8'h07, 2, 2, K_NONE, 7'h00, 32'h0);
    send(8'hAA, 2, 2, K_NONE, 7'h00, 32'h0);
    chk("midreset_busy_before", 64'(o_busy), 64'd1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    send(8'h02, 2, 2, K_NONE, 7'h00, 32'h0);
    send(8'h01, 2, 2, K_NONE, 7'h00, 32'h0);
    send(8'h02, 2, 2, K_NONE, 7'h00, 32'h0);
    send(8'h03, 2, 2, K_NONE, 7'h00, 32'h0);
    send(8'h04, 2, 4, K_WR,   7'h02, 32'h01020304);
    chk("final_wdata", 64'(o_wdata), 64'h01020304);
    chk("final_busy",  64'(o_busy),  64'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
